// File: rtl/mem_map_pkg.sv
// Shared memory-map constants: region bases, region indices and the
// response FSM state encoding used by the response mux.
package mem_map_pkg;

  localparam logic [15:0] FLASH_BASE  = 16'h0000;
  localparam logic [15:0] BRAM_BASE   = 16'h0001;
  localparam logic [15:0] SRAM_BASE   = 16'h0002;
  localparam logic [15:0] PERIPH_BASE = 16'h0003;

  localparam logic [1:0] FLASH  = 2'd0;
  localparam logic [1:0] BRAM   = 2'd1;
  localparam logic [1:0] SRAM   = 2'd2;
  localparam logic [1:0] PERIPH = 2'd3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // One-hot slave select for a region index.
  function automatic logic [3:0] region_onehot(input logic [1:0] region);
    return 4'b0001 << region;
  endfunction

endpackage

// File: rtl/mem_region_lookup.sv
// Combinational region decode of addr[31:16] into a slave index plus an
// unmapped flag; usable by any bus master.
module mem_region_lookup
  import mem_map_pkg::*;
(
  input  logic [15:0] addr_hi,
  output logic [1:0]  region,
  output logic        unmapped
);

  always_comb begin
    region   = FLASH;
    unmapped = 1'b0;
    case (addr_hi)
      FLASH_BASE:  region = FLASH;
      BRAM_BASE:   region = BRAM;
      SRAM_BASE:   region = SRAM;
      PERIPH_BASE: region = PERIPH;
      default:     unmapped = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_response_mux.sv
// Single-outstanding CPU memory transaction: decode region, pulse the slave
// request, wait for its ack and return data or error. MEM_TIMEOUT_EN adds a
// wait-state limit that forces an error response.
module mem_response_mux
  import mem_map_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic [31:0]         cpu_addr,
  input  logic                cpu_we,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_busy,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_error,
  output logic [3:0]          slv_req,
  output logic [31:0]         slv_addr,
  output logic                slv_we,
  output logic [DATA_W-1:0]   slv_wdata,
  input  logic [3:0]          slv_ack,
  input  logic [4*DATA_W-1:0] slv_rdata
);

  logic [1:0]        state;
  logic [1:0]        region_q;
  logic [1:0]        lk_region;
  logic              lk_unmapped;
  logic [3:0]        slv_req_q;
  logic [31:0]       addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              error_q;
  logic [DATA_W-1:0] sel_rdata;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;
  logic [CNT_W-1:0] wait_cnt;
`endif

  mem_region_lookup u_lookup (
    .addr_hi  (cpu_addr[31:16]),
    .region   (lk_region),
    .unmapped (lk_unmapped)
  );

  assign sel_rdata = slv_rdata[int'(region_q)*DATA_W +: DATA_W];

  // Only the selected slave's ack counts; others are ignored while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      region_q  <= FLASH;
      slv_req_q <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      slv_req_q <= '0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            addr_q   <= cpu_addr;
            we_q     <= cpu_we;
            wdata_q  <= cpu_wdata;
            region_q <= lk_region;
            if (lk_unmapped) begin
              rdata_q <= '0;
              error_q <= 1'b1;
              state   <= RESP;
            end else begin
              slv_req_q <= region_onehot(lk_region);
              state     <= WAIT;
`ifdef MEM_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end
          end
        end
        WAIT: begin
          if (slv_ack[region_q]) begin
            rdata_q <= we_q ? '0 : sel_rdata;
            error_q <= 1'b0;
            state   <= RESP;
          end
`ifdef MEM_TIMEOUT_EN
          // An ack in the final allowed cycle takes priority over the timeout.
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rdata_q <= '0;
            error_q <= 1'b1;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_busy   = (state != IDLE);
  assign cpu_rvalid = (state == RESP);
  assign cpu_rdata  = cpu_rvalid ? rdata_q : '0;
  assign cpu_error  = cpu_rvalid & error_q;
  assign slv_req    = slv_req_q;
  assign slv_addr   = addr_q;
  assign slv_we     = we_q;
  assign slv_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_response_mux.sv
// Randomized self-checking bench for mem_response_mux; expected responses
// come from a transaction-level model of latency, decode and ack rules.
module tb_mem_response_mux;

`ifdef MEM_TIMEOUT_EN
  localparam int TIMEOUT = 4;
  localparam int MAX_D   = 7;
`else
  localparam int TIMEOUT = 1 << 30;
  localparam int MAX_D   = 5;
`endif

  logic         clk;
  logic         reset;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic         cpu_we;
  logic [31:0]  cpu_wdata;
  logic         cpu_busy;
  logic         cpu_rvalid;
  logic [31:0]  cpu_rdata;
  logic         cpu_error;
  logic [3:0]   slv_req;
  logic [31:0]  slv_addr;
  logic         slv_we;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_ack;
  logic [127:0] slv_rdata;

  int check_count;
  int pass_count;

  mem_response_mux #(
    .DATA_W         (32),
`ifdef MEM_TIMEOUT_EN
    .TIMEOUT_CYCLES (TIMEOUT)
`else
    .TIMEOUT_CYCLES (255)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_busy   (cpu_busy),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_error  (cpu_error),
    .slv_req    (slv_req),
    .slv_addr   (slv_addr),
    .slv_we     (slv_we),
    .slv_wdata  (slv_wdata),
    .slv_ack    (slv_ack),
    .slv_rdata  (slv_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      pass_count++;
  endtask

  // One transaction, called at a negedge with the block idle; d is the number
  // of cycles after the request pulse before the selected slave acks.
  task automatic apply_stimulus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                                input int d, input logic [31:0] srdata, input bit junk);
    bit          mapped;
    int          reg_i;
    int          resp_j;
    int          last;
    logic [3:0]  onehot;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [3:0]  spur;

    mapped = (addr[31:16] < 16'd4);
    reg_i  = int'(addr[17:16]);
    onehot = mapped ? 4'(1 << reg_i) : 4'b0000;
    if (!mapped) begin
      resp_j = 1; exp_rd = '0; exp_err = 1'b1;
    end else if (d < TIMEOUT) begin
      resp_j = 2 + d; exp_rd = we ? 32'h0 : srdata; exp_err = 1'b0;
    end else begin
      resp_j = 1 + TIMEOUT; exp_rd = '0; exp_err = 1'b1;
    end
    last = resp_j;
    if (mapped && (1 + d) > last) last = 1 + d;

    for (int i = 0; i < 4; i++)
      slv_rdata[i*32 +: 32] = (mapped && i == reg_i) ? srdata : $urandom;

    check_output("idle_busy", {63'd0, cpu_busy}, 64'd0);
    check_output("idle_rvalid", {63'd0, cpu_rvalid}, 64'd0);
    cpu_req   = 1'b1;
    cpu_addr  = addr;
    cpu_we    = we;
    cpu_wdata = wdata;
    slv_ack   = 4'b0000;

    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      check_output("busy", {63'd0, cpu_busy}, {63'd0, (j <= resp_j)});
      check_output("rvalid", {63'd0, cpu_rvalid}, {63'd0, (j == resp_j)});
      check_output("slv_req", {60'd0, slv_req}, {60'd0, (j == 1) ? onehot : 4'b0000});
      if (j == resp_j) begin
        check_output("rdata", {32'd0, cpu_rdata}, {32'd0, exp_rd});
        check_output("error", {63'd0, cpu_error}, {63'd0, exp_err});
      end
      if (j == 1 || j == resp_j) begin
        check_output("slv_addr", {32'd0, slv_addr}, {32'd0, addr});
        check_output("slv_we", {63'd0, slv_we}, {63'd0, we});
        check_output("slv_wdata", {32'd0, slv_wdata}, {32'd0, wdata});
      end
      if (junk && j <= resp_j) begin
        cpu_req   = 1'b1;
        cpu_addr  = {14'd0, 2'($urandom), 16'($urandom)};
        cpu_we    = 1'($urandom);
        cpu_wdata = $urandom;
      end else begin
        cpu_req = 1'b0;
      end
      spur    = junk ? (4'($urandom) & ~onehot) : 4'b0000;
      slv_ack = spur | ((mapped && j == 1 + d) ? onehot : 4'b0000);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    slv_ack = 4'b0000;
  endtask

  initial begin
    logic [15:0] hi;
    int          r;
    check_count = 0;
    pass_count  = 0;
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_addr  = '0;
    cpu_we    = 1'b0;
    cpu_wdata = '0;
    slv_ack   = 4'b0000;
    slv_rdata = '0;

    repeat (2) @(negedge clk);
    check_output("rst_busy", {63'd0, cpu_busy}, 64'd0);
    check_output("rst_slv_req", {60'd0, slv_req}, 64'd0);
    check_output("rst_slv_addr", {32'd0, slv_addr}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed transactions");
    apply_stimulus(32'h0001_0010, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    apply_stimulus(32'h0002_0004, 1'b1, 32'h1234_5678, 3, 32'hCAFE_F00D, 1'b0);
    apply_stimulus(32'h0005_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    apply_stimulus(32'h0003_0000, 1'b0, 32'h0, 2, 32'hA5A5_A5A5, 1'b1);
`ifdef MEM_TIMEOUT_EN
    apply_stimulus(32'h0000_0100, 1'b0, 32'h0, 6, 32'h1111_2222, 1'b0);
    apply_stimulus(32'h0000_0200, 1'b0, 32'h0, TIMEOUT - 1, 32'h3333_4444, 1'b0);
`endif

    $display("[TB] reset during WAIT");
    cpu_req  = 1'b1;
    cpu_addr = 32'h0002_0040;
    cpu_we   = 1'b1;
    cpu_wdata = 32'h5555_AAAA;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("midrst_busy", {63'd0, cpu_busy}, 64'd0);
    check_output("midrst_rvalid", {63'd0, cpu_rvalid}, 64'd0);
    check_output("midrst_rdata", {32'd0, cpu_rdata}, 64'd0);
    check_output("midrst_error", {63'd0, cpu_error}, 64'd0);
    check_output("midrst_slv_addr", {32'd0, slv_addr}, 64'd0);
    check_output("midrst_slv_we", {63'd0, slv_we}, 64'd0);
    check_output("midrst_slv_wdata", {32'd0, slv_wdata}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    apply_stimulus(32'h0001_0ABC, 1'b0, 32'h0, 1, 32'h0BAD_F00D, 1'b0);

    $display("[TB] random transactions");
    for (int t = 0; t < 40; t++) begin
      r  = $urandom_range(0, 4);
      hi = (r == 4) ? 16'($urandom_range(4, 65535)) : 16'(r);
      apply_stimulus({hi, 16'($urandom)}, 1'($urandom), $urandom,
                     $urandom_range(0, MAX_D), $urandom, 1'($urandom));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
